// File: rtl/train_traffic_control.sv
// Single-track section arbiter: round-robin grant of one of four trains, held until the
// granted train reports done or the occupancy timeout expires.
module train_traffic_control #(
    parameter int unsigned TIMEOUT_CYCLES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] train_request,
    input  logic       train_done,
    output logic [2:0] grant
);

    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    // State encoding doubles as the grant code driven to the interlocking.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGrantT1 = 3'd1,
        StGrantT2 = 3'd2,
        StGrantT3 = 3'd3,
        StGrantT4 = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      last_q, last_d;

    logic            pick_valid;
    logic [1:0]      pick;
    logic [1:0]      idx;

    // Search starts at the train after the last one served and wraps around.
    always_comb begin
        pick_valid = 1'b0;
        pick       = last_q;
        idx        = last_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!pick_valid && train_request[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = state_e'({1'b0, pick} + 3'd1);
                    last_d  = pick;
                end
            end
            StGrantT1, StGrantT2, StGrantT3, StGrantT4: begin
                cnt_d = cnt_q + CntW'(1);
                if (train_done || (cnt_q == CntLast)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign grant = state_q;

endmodule

// File: tb/tb_train_traffic_control.sv
// Directed bench for train_traffic_control: inputs change and outputs are checked on the
// falling edge, so each step() spans exactly one sampling rising edge.
module tb_train_traffic_control;

    logic       clk;
    logic       reset;
    logic [3:0] train_request;
    logic       train_done;
    logic [2:0] grant;

    int n_checks = 0;
    int n_fail   = 0;

    train_traffic_control #(
        .TIMEOUT_CYCLES(5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .train_request(train_request),
        .train_done   (train_done),
        .grant        (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] actual, input logic [2:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: grant=%b expected=%b at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] rr_seq [5];
        rr_seq[0] = 3'b001;
        rr_seq[1] = 3'b010;
        rr_seq[2] = 3'b011;
        rr_seq[3] = 3'b100;
        rr_seq[4] = 3'b001;

        reset         = 1'b0;
        train_request = 4'b0000;
        train_done    = 1'b0;

        // Reset and idle.
        step();
        step();
        check("reset_state", grant, 3'b000);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("idle_%0d", i), grant, 3'b000);
        end

        // Single grants T1..T4, each released by done after 3 granted cycles.
        for (int t = 0; t < 4; t++) begin
            train_request = 4'b0001 << t;
            step();
            check($sformatf("single_T%0d_c1", t + 1), grant, 3'(t + 1));
            train_request = 4'b0000;
            step();
            check($sformatf("single_T%0d_c2", t + 1), grant, 3'(t + 1));
            step();
            check($sformatf("single_T%0d_c3", t + 1), grant, 3'(t + 1));
            train_done = 1'b1;
            step();
            check($sformatf("single_T%0d_rel", t + 1), grant, 3'b000);
            train_done = 1'b0;
        end

        // Timeout: exactly 5 granted cycles, one idle cycle, then re-grant.
        train_request = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("timeout_hold_%0d", i), grant, 3'b001);
        end
        step();
        check("timeout_idle", grant, 3'b000);
        step();
        check("timeout_regrant", grant, 3'b001);
        train_request = 4'b0000;
        train_done    = 1'b1;
        step();
        check("timeout_done_rel", grant, 3'b000);
        train_done = 1'b0;

        // Round-robin after a fresh reset with all trains requesting.
        reset = 1'b0;
        step();
        check("rr_reset", grant, 3'b000);
        reset         = 1'b1;
        train_request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr_%0d_c1", k), grant, rr_seq[k]);
            step();
            check($sformatf("rr_%0d_c2", k), grant, rr_seq[k]);
            train_done = 1'b1;
            step();
            check($sformatf("rr_%0d_gap", k), grant, 3'b000);
            train_done = 1'b0;
        end
        train_request = 4'b0000;
        step();
        check("rr_end_idle", grant, 3'b000);

        // Request drop keeps the grant; stray done in idle is ignored.
        train_request = 4'b0100;
        step();
        check("drop_grant", grant, 3'b011);
        train_request = 4'b0000;
        step();
        check("drop_hold_1", grant, 3'b011);
        step();
        check("drop_hold_2", grant, 3'b011);
        train_done = 1'b1;
        step();
        check("drop_rel", grant, 3'b000);
        step();
        check("stray_done_1", grant, 3'b000);
        step();
        check("stray_done_2", grant, 3'b000);
        train_done = 1'b0;

        // Asynchronous reset mid-grant, then T1 has first priority.
        train_request = 4'b0010;
        step();
        check("midreset_grant", grant, 3'b010);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_async", grant, 3'b000);
        train_request = 4'b1111;
        step();
        check("midreset_held", grant, 3'b000);
        reset = 1'b1;
        step();
        check("midreset_first", grant, 3'b001);
        train_request = 4'b0000;
        train_done    = 1'b1;
        step();
        check("midreset_rel", grant, 3'b000);
        train_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/train_traffic_control.md
# train_traffic_control

Single-track section arbiter that grants exclusive access to one of four trains. It samples four request lines while idle and issues a 3-bit encoded grant. The grant is held until the granted train reports completion or a fixed occupancy timeout expires. It sits between the trackside request sensors and the signalling/interlocking logic, and drives the section's "who may enter" code.

## Interface
- TIMEOUT_CYCLES, default 5: maximum number of consecutive cycles a grant may be held; legal range 2..255.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low forces the reset state immediately; release is synchronised by the user.
- train_request  input  4  bit i high means train T(i+1) requests the section; level-sensitive.
- train_done  input  1  the currently granted train has cleared the section; level, sampled each cycle.
- grant  output  3  encoded owner: 000 none (IDLE), 001 T1, 010 T2, 011 T3, 100 T4. Codes 101–111 are never driven.

## Operation
- States: IDLE, GRANT_T1, GRANT_T2, GRANT_T3, GRANT_T4. `grant` is a registered Moore output equal to the state code above.
- Internal registers:
  - occupancy counter, width ceil(log2(TIMEOUT_CYCLES))+1;
  - 2-bit last-served pointer `last`.
- IDLE:
  - If `train_request` is 0000, stay in IDLE.
  - Otherwise select one requester by round-robin.
  - Search order starts at the train after `last` and wraps: T1→T2→T3→T4→T1.
  - Go to that train's GRANT state, load the counter with 0, and set `last` to that train.
- GRANT_Tn:
  - Each cycle in the state, the counter increments by 1.
  - If `train_done`=1, go to IDLE (normal release).
  - Else if the counter equals TIMEOUT_CYCLES-1, go to IDLE (timeout release).
  - Else stay in GRANT_Tn.
  - `train_request` is ignored while granted. Dropping or changing requests does not revoke or move the grant.
- `train_done` is ignored in IDLE.
- Simultaneous done and timeout in the same cycle: normal release to IDLE (identical result).
- Every release passes through IDLE for at least one cycle. The section is never handed directly from one train to another.
- Reset (asserted at any time, including mid-grant):
  - state IDLE, `grant`=000;
  - counter 0;
  - `last`=T4, so T1 has first priority after reset.

## Timing
- Grant latency: a request present at rising edge k while IDLE gives `grant` valid after edge k. The grant is visible in the cycle following the sampling edge (1 cycle).
- Release latency: `train_done` high at edge k gives `grant`=000 after edge k.
- Maximum grant duration: exactly TIMEOUT_CYCLES cycles, measured from the first cycle `grant`≠000 to the last.
- A request held continuously through a timeout is re-granted after exactly one IDLE cycle, provided no other train is requesting. If another train is requesting, round-robin hands the section to it.
- Minimum IDLE gap between grants: 1 cycle. With continuous contention, each train waits at most 3×(TIMEOUT_CYCLES+1) cycles.
- No combinational path from inputs to `grant`.
- Asynchronous reset clears `grant` without waiting for a clock edge.

## Test plan
- Reset and idle: `reset` low, then high with `train_request`=0000 for 3 cycles -> `grant`=000 throughout. Assert `reset` low mid-cycle -> `grant`=000 immediately.
- Single grants: `train_request`=0001, then 0010, then 0100, then 1000, each followed by `train_done` pulsed 1 cycle after 3 granted cycles -> `grant`=001, 010, 011, 100 respectively. Each grant is one cycle after its request and returns to 000 one cycle after `train_done`.
- Timeout: `train_request`=0001 held, `train_done`=0, TIMEOUT_CYCLES=5 -> `grant`=001 for exactly 5 cycles, then 000 for 1 cycle, then 001 again.
- Round-robin: after reset, `train_request`=1111 held, `train_done` pulsed each time a grant has been held 2 cycles -> grant sequence 001, 010, 011, 100, 001, with a 000 cycle between each.
- Request drop and stray done: grant T3 (0100), then drop `train_request` to 0000 -> `grant` stays 011 until `train_done` or timeout. Pulsing `train_done` while IDLE -> `grant` stays 000.
- Reset mid-grant: while `grant`=010, assert `reset` -> `grant`=000 immediately. After release with `train_request`=1111, the first grant is 001.
